// File: rtl/vixen_mem_arbiter_if.sv
// Bus bundle between the CPU, the video fetch unit, the arbiter and the hi/lo RAM lanes.
interface vixen_mem_arbiter_if;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BE_W   = 2;

  // CPU side
  logic              cpu_req;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [BE_W-1:0]   cpu_be;
  logic [DATA_W-1:0] cpu_din;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_dout;

  // Video fetch side
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic [DATA_W-1:0] vid_dout;

  // RAM lanes ([15:8] hi / even byte, [7:0] lo / odd byte)
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic              mem_en_hi;
  logic              mem_en_lo;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  // Arbiter view
  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_be, cpu_din,
    output cpu_ack, cpu_dout,
    input  vid_req, vid_addr,
    output vid_ack, vid_dout,
    output mem_addr, mem_wr, mem_en_hi, mem_en_lo, mem_din,
    input  mem_dout
  );

  // Requester / RAM environment view
  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_be, cpu_din,
    input  cpu_ack, cpu_dout,
    output vid_req, vid_addr,
    input  vid_ack, vid_dout,
    input  mem_addr, mem_wr, mem_en_hi, mem_en_lo, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/vixen_mem_arbiter.sv
// Shares the 16-bit main RAM between the CPU and video fetch.
// One access per IDLE -> ACC -> DONE sequence; video has priority, bounded by a streak counter.
module vixen_mem_arbiter #(
  parameter int unsigned VID_BURST = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  vixen_mem_arbiter_if.slave bus
);

  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned STREAK_W = 4;
  localparam logic [STREAK_W-1:0] BURST_MAX = STREAK_W'(VID_BURST);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q,     state_d;
  logic                owner_vid_q, owner_vid_d;
  logic                acc_wr_q,    acc_wr_d;
  logic [STREAK_W-1:0] streak_q,    streak_d;
  logic                cpu_ack_q,   cpu_ack_d;
  logic                vid_ack_q,   vid_ack_d;
  logic [DATA_W-1:0]   cpu_dout_q,  cpu_dout_d;
  logic [DATA_W-1:0]   vid_dout_q,  vid_dout_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic                mem_wr_q,    mem_wr_d;
  logic                mem_en_hi_q, mem_en_hi_d;
  logic                mem_en_lo_q, mem_en_lo_d;
  logic [DATA_W-1:0]   mem_din_q,   mem_din_d;

  logic grant_vid_c;
  logic grant_cpu_c;

  // Arbitration: video wins unless it has used up its streak while the CPU waits.
  always_comb begin
    grant_vid_c = 1'b0;
    grant_cpu_c = 1'b0;
    if (bus.vid_req && (!bus.cpu_req || (streak_q != BURST_MAX))) begin
      grant_vid_c = 1'b1;
    end else if (bus.cpu_req) begin
      grant_cpu_c = 1'b1;
    end
  end

  // Next-state and registered-output logic; mem fields are latched at grant and live only in ACC.
  always_comb begin
    state_d     = state_q;
    owner_vid_d = owner_vid_q;
    acc_wr_d    = acc_wr_q;
    streak_d    = streak_q;
    cpu_ack_d   = 1'b0;
    vid_ack_d   = 1'b0;
    cpu_dout_d  = cpu_dout_q;
    vid_dout_d  = vid_dout_q;
    mem_addr_d  = mem_addr_q;
    mem_wr_d    = mem_wr_q;
    mem_en_hi_d = mem_en_hi_q;
    mem_en_lo_d = mem_en_lo_q;
    mem_din_d   = mem_din_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_vid_c) begin
          owner_vid_d = 1'b1;
          acc_wr_d    = 1'b0;
          mem_addr_d  = bus.vid_addr;
          mem_wr_d    = 1'b0;
          mem_en_hi_d = 1'b1;
          mem_en_lo_d = 1'b1;
          mem_din_d   = '0;
          if (!bus.cpu_req) begin
            streak_d = '0;
          end else if (streak_q != BURST_MAX) begin
            streak_d = STREAK_W'(streak_q + STREAK_W'(1));
          end
          state_d = ST_ACC;
        end else if (grant_cpu_c) begin
          owner_vid_d = 1'b0;
          acc_wr_d    = bus.cpu_wr;
          mem_addr_d  = bus.cpu_addr;
          mem_wr_d    = bus.cpu_wr;
          mem_en_hi_d = bus.cpu_wr ? bus.cpu_be[1] : 1'b1;
          mem_en_lo_d = bus.cpu_wr ? bus.cpu_be[0] : 1'b1;
          mem_din_d   = bus.cpu_wr ? bus.cpu_din : '0;
          streak_d    = '0;
          state_d     = ST_ACC;
        end
      end

      ST_ACC: begin
        if (owner_vid_q) begin
          vid_dout_d = bus.mem_dout;
          vid_ack_d  = 1'b1;
        end else begin
          if (!acc_wr_q) begin
            cpu_dout_d = bus.mem_dout;
          end
          cpu_ack_d = 1'b1;
        end
        mem_addr_d  = '0;
        mem_wr_d    = 1'b0;
        mem_en_hi_d = 1'b0;
        mem_en_lo_d = 1'b0;
        mem_din_d   = '0;
        state_d     = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any in-flight access without an ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      owner_vid_q <= 1'b0;
      acc_wr_q    <= 1'b0;
      streak_q    <= '0;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      cpu_dout_q  <= '0;
      vid_dout_q  <= '0;
      mem_addr_q  <= '0;
      mem_wr_q    <= 1'b0;
      mem_en_hi_q <= 1'b0;
      mem_en_lo_q <= 1'b0;
      mem_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_vid_q <= owner_vid_d;
      acc_wr_q    <= acc_wr_d;
      streak_q    <= streak_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_ack_q   <= vid_ack_d;
      cpu_dout_q  <= cpu_dout_d;
      vid_dout_q  <= vid_dout_d;
      mem_addr_q  <= mem_addr_d;
      mem_wr_q    <= mem_wr_d;
      mem_en_hi_q <= mem_en_hi_d;
      mem_en_lo_q <= mem_en_lo_d;
      mem_din_q   <= mem_din_d;
    end
  end

  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_dout  = cpu_dout_q;
  assign bus.vid_ack   = vid_ack_q;
  assign bus.vid_dout  = vid_dout_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_en_hi = mem_en_hi_q;
  assign bus.mem_en_lo = mem_en_lo_q;
  assign bus.mem_din   = mem_din_q;

endmodule

// File: tb/tb_vixen_mem_arbiter.sv
// Self-checking bench for vixen_mem_arbiter: RAM lane model, reference memory and ack scoreboard.
module tb_vixen_mem_arbiter;

  localparam int unsigned VID_BURST = 4;
  localparam int unsigned DEPTH     = 32768;

  typedef struct packed {
    logic        rd;
    logic [15:0] data;
  } exp_t;

  typedef struct packed {
    logic vid;
    int   c;
  } ack_t;

  logic clk;
  logic reset_n;

  vixen_mem_arbiter_if bus();

  vixen_mem_arbiter #(.VID_BURST(VID_BURST)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM lanes and the bench's own reference copy
  logic [7:0]  ram_hi  [0:DEPTH-1];
  logic [7:0]  ram_lo  [0:DEPTH-1];
  logic [15:0] ref_mem [0:DEPTH-1];

  assign bus.mem_dout = {ram_hi[bus.mem_addr], ram_lo[bus.mem_addr]};

  always @(posedge clk) begin
    if (bus.mem_wr && bus.mem_en_hi) ram_hi[bus.mem_addr] <= bus.mem_din[15:8];
    if (bus.mem_wr && bus.mem_en_lo) ram_lo[bus.mem_addr] <= bus.mem_din[7:0];
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   wr_cycles = 0;
  exp_t cpu_q[$];
  exp_t vid_q[$];
  ack_t ack_log[$];
  logic [15:0] last_cpu_rd = 16'h0000;
  logic prev_cpu_ack = 1'b0;
  logic prev_vid_ack = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Ack monitor: pops the scoreboard and checks returned data and pulse shape
  initial forever begin
    exp_t e;
    ack_t a;
    logic [15:0] exp_d;
    @(negedge clk);
    if (!reset_n) begin
      prev_cpu_ack = 1'b0;
      prev_vid_ack = 1'b0;
    end else begin
      if (bus.mem_wr) wr_cycles++;
      if (bus.cpu_ack || bus.vid_ack) begin
        n_checks++;
        if (bus.cpu_ack && bus.vid_ack) begin
          n_fail++;
          $display("FAIL dual_ack: cpu_ack=1 vid_ack=1 at cycle %0d, required at most one", cyc);
        end
      end
      if (bus.cpu_ack) begin
        a.vid = 1'b0; a.c = cyc; ack_log.push_back(a);
        n_checks++;
        if (prev_cpu_ack) begin
          n_fail++;
          $display("FAIL cpu_ack_width: ack high two cycles in a row at cycle %0d, required one", cyc);
        end
        n_checks++;
        if (cpu_q.size() == 0) begin
          n_fail++;
          $display("FAIL cpu_unexpected_ack: ack at cycle %0d, required none", cyc);
        end else begin
          e = cpu_q.pop_front();
          exp_d = e.rd ? e.data : last_cpu_rd;
          if (bus.cpu_dout !== exp_d) begin
            n_fail++;
            $display("FAIL cpu_dout: got %h, required %h (rd=%0b)", bus.cpu_dout, exp_d, e.rd);
          end
          if (e.rd) last_cpu_rd = e.data;
        end
      end
      if (bus.vid_ack) begin
        a.vid = 1'b1; a.c = cyc; ack_log.push_back(a);
        n_checks++;
        if (prev_vid_ack) begin
          n_fail++;
          $display("FAIL vid_ack_width: ack high two cycles in a row at cycle %0d, required one", cyc);
        end
        n_checks++;
        if (vid_q.size() == 0) begin
          n_fail++;
          $display("FAIL vid_unexpected_ack: ack at cycle %0d, required none", cyc);
        end else begin
          e = vid_q.pop_front();
          if (bus.vid_dout !== e.data) begin
            n_fail++;
            $display("FAIL vid_dout: got %h, required %h", bus.vid_dout, e.data);
          end
        end
      end
      prev_cpu_ack = bus.cpu_ack;
      prev_vid_ack = bus.vid_ack;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Push the expectation for a CPU access, updating the reference memory on writes
  task automatic cpu_expect(input logic wr, input logic [14:0] a, input logic [1:0] be, input logic [15:0] d);
    exp_t e;
    logic [15:0] v;
    if (wr) begin
      v = ref_mem[a];
      if (be[1]) v[15:8] = d[15:8];
      if (be[0]) v[7:0]  = d[7:0];
      ref_mem[a] = v;
      e.rd = 1'b0; e.data = 16'h0000;
    end else begin
      e.rd = 1'b1; e.data = ref_mem[a];
    end
    cpu_q.push_back(e);
  endtask

  task automatic vid_expect(input logic [14:0] a);
    exp_t e;
    e.rd = 1'b1; e.data = ref_mem[a];
    vid_q.push_back(e);
  endtask

  // One CPU access from an idle arbiter; returns negedges from request to ack
  task automatic cpu_txn(input logic wr, input logic [14:0] a, input logic [1:0] be,
                         input logic [15:0] d, output int lat);
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_wr = wr; bus.cpu_addr = a; bus.cpu_be = be; bus.cpu_din = d;
    cpu_expect(wr, a, be, d);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.cpu_ack && lat < 40);
    if (!bus.cpu_ack) begin
      n_checks++; n_fail++;
      $display("FAIL cpu_timeout: no cpu_ack within %0d cycles, required ack", lat);
      void'(cpu_q.pop_back());
    end
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_be = '0; bus.cpu_din = '0;
    bus.vid_req = 1'b0; bus.vid_addr = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.cpu_ack, bus.vid_ack} !== 2'b00) begin
      n_fail++; $display("FAIL reset_acks: got %b, required 00", {bus.cpu_ack, bus.vid_ack});
    end
    n_checks++;
    if ({bus.cpu_dout, bus.vid_dout} !== 32'h0) begin
      n_fail++; $display("FAIL reset_dout: got %h, required 0", {bus.cpu_dout, bus.vid_dout});
    end
    n_checks++;
    if ({bus.mem_wr, bus.mem_en_hi, bus.mem_en_lo, bus.mem_addr, bus.mem_din} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_mem: wr=%b en=%b%b addr=%h din=%h, required all 0",
               bus.mem_wr, bus.mem_en_hi, bus.mem_en_lo, bus.mem_addr, bus.mem_din);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.mem_en_hi, bus.mem_en_lo, bus.cpu_ack, bus.vid_ack} !== 4'b0000) begin
      n_fail++; $display("FAIL idle_after_reset: got %b, required 0000",
                         {bus.mem_en_hi, bus.mem_en_lo, bus.cpu_ack, bus.vid_ack});
    end
  endtask

  task automatic test_cpu_rw();
    int lat;
    int w0;
    w0 = wr_cycles;
    cpu_txn(1'b1, 15'h0010, 2'b11, 16'hBEEF, lat);
    n_checks++;
    if (lat != 3) begin n_fail++; $display("FAIL wr_latency: got %0d, required 3", lat); end
    n_checks++;
    if (wr_cycles - w0 != 1) begin n_fail++; $display("FAIL wr_strobe_cycles: got %0d, required 1", wr_cycles - w0); end
    w0 = wr_cycles;
    cpu_txn(1'b0, 15'h0010, 2'b11, 16'h0000, lat);
    n_checks++;
    if (lat != 3) begin n_fail++; $display("FAIL rd_latency: got %0d, required 3", lat); end
    n_checks++;
    if (wr_cycles - w0 != 0) begin n_fail++; $display("FAIL rd_strobe_cycles: got %0d, required 0", wr_cycles - w0); end
    n_checks++;
    if (bus.cpu_dout !== 16'hBEEF) begin n_fail++; $display("FAIL rd_beef: got %h, required beef", bus.cpu_dout); end
  endtask

  task automatic test_byte_lanes();
    int lat;
    cpu_txn(1'b1, 15'h0020, 2'b11, 16'h1234, lat);
    cpu_txn(1'b1, 15'h0020, 2'b10, 16'hAB00, lat);
    cpu_txn(1'b0, 15'h0020, 2'b11, 16'h0000, lat);
    n_checks++;
    if (bus.cpu_dout !== 16'hAB34) begin n_fail++; $display("FAIL be_merge: got %h, required ab34", bus.cpu_dout); end
    cpu_txn(1'b1, 15'h0020, 2'b00, 16'h0099, lat);
    n_checks++;
    if (lat != 3) begin n_fail++; $display("FAIL be00_ack_latency: got %0d, required 3", lat); end
    cpu_txn(1'b0, 15'h0020, 2'b11, 16'h0000, lat);
    n_checks++;
    if (bus.cpu_dout !== 16'hAB34) begin n_fail++; $display("FAIL be00_no_write: got %h, required ab34", bus.cpu_dout); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] got;
    logic [9:0] want;
    logic gaps_ok;
    int n;
    want = 10'b0111101111;
    for (int i = 0; i < 8; i++) vid_expect(15'h0100);
    for (int i = 0; i < 2; i++) cpu_expect(1'b0, 15'h0010, 2'b11, 16'h0000);
    ack_log.delete();
    @(posedge clk); #1;
    bus.vid_addr = 15'h0100; bus.vid_req = 1'b1;
    bus.cpu_wr = 1'b0; bus.cpu_addr = 15'h0010; bus.cpu_be = 2'b11; bus.cpu_req = 1'b1;
    n = 0;
    while (ack_log.size() < 10 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    bus.vid_req = 1'b0; bus.cpu_req = 1'b0;
    n_checks++;
    if (ack_log.size() != 10) begin
      n_fail++; $display("FAIL b2b_count: got %0d acks, required 10", ack_log.size());
    end else begin
      got = '0;
      gaps_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
        got[i] = ack_log[i].vid;
        if (i > 0 && ack_log[i].c - ack_log[i-1].c != 3) gaps_ok = 1'b0;
      end
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL b2b_order: got %b, required %b (bit0 first, 1=video)", got, want); end
      n_checks++;
      if (!gaps_ok) begin n_fail++; $display("FAIL b2b_spacing: ack spacing not 3 cycles, required 3"); end
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (cpu_q.size() + vid_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_leftover: got %0d pending, required 0", cpu_q.size() + vid_q.size());
    end
  endtask

  task automatic test_late_cpu();
    int nv;
    int n;
    for (int i = 0; i < 5; i++) vid_expect(15'h0140);
    cpu_expect(1'b0, 15'h0020, 2'b11, 16'h0000);
    ack_log.delete();
    @(posedge clk); #1;
    bus.vid_addr = 15'h0140; bus.vid_req = 1'b1;
    @(posedge clk); #1;
    bus.cpu_wr = 1'b0; bus.cpu_addr = 15'h0020; bus.cpu_be = 2'b11; bus.cpu_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cpu_ack && n < 60);
    @(posedge clk); #1;
    bus.vid_req = 1'b0; bus.cpu_req = 1'b0;
    nv = 0;
    foreach (ack_log[i]) if (ack_log[i].vid) nv++;
    n_checks++;
    if (nv != 5 || ack_log.size() != 6 || ack_log[ack_log.size()-1].vid !== 1'b0) begin
      n_fail++; $display("FAIL late_cpu_order: got %0d video acks of %0d total, required 5 video then cpu", nv, ack_log.size());
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (cpu_q.size() + vid_q.size() != 0) begin
      n_fail++; $display("FAIL late_cpu_leftover: got %0d pending, required 0", cpu_q.size() + vid_q.size());
    end
  endtask

  task automatic test_reset_mid_access();
    int lat;
    cpu_txn(1'b1, 15'h0030, 2'b11, 16'h5555, lat);
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_addr = 15'h0030; bus.cpu_be = 2'b11; bus.cpu_din = 16'hCAFE;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.mem_wr !== 1'b1) begin n_fail++; $display("FAIL mid_acc_wr: got %b, required 1", bus.mem_wr); end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.mem_wr, bus.mem_en_hi, bus.mem_en_lo, bus.cpu_ack} !== 4'b0000 || bus.cpu_dout !== 16'h0000) begin
      n_fail++; $display("FAIL mid_reset_outputs: wr/en/ack=%b dout=%h, required 0000/0000",
                         {bus.mem_wr, bus.mem_en_hi, bus.mem_en_lo, bus.cpu_ack}, bus.cpu_dout);
    end
    last_cpu_rd = 16'h0000;
    bus.cpu_req = 1'b0;
    ack_log.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (ack_log.size() != 0) begin n_fail++; $display("FAIL mid_reset_ack: got %0d acks, required 0", ack_log.size()); end
    cpu_txn(1'b0, 15'h0030, 2'b11, 16'h0000, lat);
    n_checks++;
    if (bus.cpu_dout !== 16'h5555) begin n_fail++; $display("FAIL mid_reset_aborted: got %h, required 5555", bus.cpu_dout); end
  endtask

  task automatic test_vid_drop();
    int c0;
    int n;
    vid_expect(15'h0200);
    ack_log.delete();
    @(posedge clk); #1;
    c0 = cyc;
    bus.vid_addr = 15'h0200; bus.vid_req = 1'b1;
    @(posedge clk); #1;
    bus.vid_req = 1'b0; bus.vid_addr = 15'h7FFF;
    bus.cpu_wr = 1'b0; bus.cpu_addr = 15'h0020; bus.cpu_be = 2'b11; bus.cpu_req = 1'b1;
    cpu_expect(1'b0, 15'h0020, 2'b11, 16'h0000);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cpu_ack && n < 40);
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    n_checks++;
    if (ack_log.size() != 2) begin
      n_fail++; $display("FAIL vid_drop_count: got %0d acks, required 2", ack_log.size());
    end else begin
      n_checks++;
      if (ack_log[0].vid !== 1'b1 || ack_log[0].c != c0 + 2) begin
        n_fail++; $display("FAIL vid_drop_ack: got vid=%b at +%0d, required vid=1 at +2", ack_log[0].vid, ack_log[0].c - c0);
      end
      n_checks++;
      if (ack_log[1].vid !== 1'b0 || ack_log[1].c != c0 + 5) begin
        n_fail++; $display("FAIL vid_drop_cpu: got vid=%b at +%0d, required vid=0 at +5", ack_log[1].vid, ack_log[1].c - c0);
      end
    end
    n_checks++;
    if (bus.vid_dout !== (16'(15'h0200) ^ 16'hA5C3)) begin
      n_fail++; $display("FAIL vid_dout_hold: got %h, required %h", bus.vid_dout, 16'(15'h0200) ^ 16'hA5C3);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = 16'(i) ^ 16'hA5C3;
      ram_hi[i]  = ref_mem[i][15:8];
      ram_lo[i]  = ref_mem[i][7:0];
    end
    test_reset();
    test_cpu_rw();
    test_byte_lanes();
    test_back_to_back();
    test_late_cpu();
    test_reset_mid_access();
    test_vid_drop();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vixen_mem_arbiter.md
Name: vixen_mem_arbiter

Overview:
- Shares the 16-bit main RAM (two 8-bit, 32K-entry byte lanes) between the CPU and the video fetch unit.
- Registers each request, drives one RAM access cycle, and returns registered read data with a one-cycle ack pulse.
- Video has priority. A streak counter bounds CPU starvation.
- Sits between the CPU bus and video fetch on one side and the hi/lo RAM lanes on the other.

Parameters:
- VID_BURST, 4, max consecutive video grants while a CPU request is pending (legal range 1..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_wr  in  1  1=write, 0=read.
- cpu_addr  in  15  word address.
- cpu_be  in  2  byte enables; [1]=even byte=bits 15:8, [0]=odd byte=bits 7:0.
- cpu_din  in  16  write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_dout  out  16  read data; valid with cpu_ack on reads.
- vid_req  in  1  video read request; held until vid_ack.
- vid_addr  in  15  word address.
- vid_ack  out  1  one-cycle completion pulse.
- vid_dout  out  16  read data; valid with vid_ack.
- mem_addr  out  15  address to both lanes.
- mem_wr  out  1  write strobe to both lanes.
- mem_en_hi  out  1  enable for even-byte lane (bits 15:8).
- mem_en_lo  out  1  enable for odd-byte lane (bits 7:0).
- mem_din  out  16  write data; [15:8] to hi lane, [7:0] to lo lane.
- mem_dout  in  16  combinational read data from the lanes.

Behaviour:
- Reset (async assert, sync release): state=IDLE, cpu_ack=vid_ack=0, cpu_dout=vid_dout=0, mem_en_hi=mem_en_lo=mem_wr=0, mem_addr=0, mem_din=0, streak=0.
- States: IDLE -> ACC -> DONE -> IDLE. Each access takes exactly 3 cycles, so max throughput is one access per 3 cycles.
- IDLE: arbitrate on the current req inputs.
  - Neither requesting: stay in IDLE.
  - Only one requesting: grant it.
  - Both requesting: grant video, unless streak==VID_BURST, in which case grant CPU.
  - On a grant, latch owner, addr, wr, be and din into internal registers, then go to ACC.
- Streak counter (4-bit, saturating at VID_BURST):
  - Increments on a video grant when cpu_req=1.
  - Clears on a CPU grant.
  - Clears on a video grant when cpu_req=0.
- ACC: mem outputs are driven from the latched registers, and only during ACC (all enables and mem_wr are 0 outside ACC).
  - CPU write: mem_wr=1, mem_en_hi=be[1], mem_en_lo=be[0], mem_din=latched din.
  - CPU read or video read: mem_wr=0, both enables=1.
  - At the end of ACC, mem_dout is captured into cpu_dout (CPU read) or vid_dout (video).
  - cpu_dout is unchanged on CPU writes.
  - Next state is DONE.
- DONE: the owner's ack is 1 for this cycle only. Next state is IDLE.
- Timing: req seen in IDLE at cycle N -> RAM access in cycle N+1 -> ack and data in cycle N+2.
  - Requester drops or changes req at the edge ending N+2.
  - IDLE at N+3 is the earliest re-arbitration.
- Input changes after a grant are ignored until DONE because all access fields are latched.
  - If req drops early, the access still completes and the ack still pulses.
- cpu_be=00 write: no lane enabled and RAM is unchanged, but the full 3-cycle sequence and cpu_ack still occur.
- cpu_dout and vid_dout hold their values between acks.
- Reset mid-access: all state returns to reset values at once, no ack is issued, and the in-flight write is aborted if reset is asserted before the ACC edge.

Test Plan:
- CPU write 0xBEEF, be=11, addr 0x0010, then CPU read of addr 0x0010 -> cpu_ack 2 cycles after each req sample; read returns cpu_dout=0xBEEF; mem_wr high only in the write's ACC cycle.
- Write 0x1234, be=11, then write 0xAB00, be=10, to addr 0x0020, then read -> 0xAB34. Write 0x0099, be=00 -> cpu_ack pulses, and a following read still returns 0xAB34.
- vid_req and cpu_req held continuously with VID_BURST=4 -> grant order V,V,V,V,C,V,V,V,V,C; each ack exactly one cycle; one access per 3 cycles.
- Both requesters hold req with cpu_req arriving one cycle after a video grant -> video completes first, then CPU granted only after streak rules; no two acks in the same cycle.
- reset_n pulsed low during the ACC of a CPU write to 0x0030 (old data 0x5555) -> outputs reset immediately, no cpu_ack, arbiter idle after release; a later read returns either 0x5555 or the new data, consistently per the edge timing.
- vid_req dropped during ACC -> vid_ack still pulses in DONE with the correct vid_dout; IDLE then grants a waiting CPU request.
